// File: rtl/issue_pkg.sv
// Shared issue-queue sizing and the entry-index type used by issue_queue,
// issue_slot and the age-matrix scheduler.
package issue_pkg;

    localparam int IQ_DEPTH = 4;
    localparam int IQ_IDX_W = $clog2(IQ_DEPTH);

    typedef logic [IQ_IDX_W-1:0] iq_idx_t;

endpackage

// File: rtl/priority_encoder.sv
// Lowest-index-wins priority encoder with both encoded and one-hot results.
module priority_encoder #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] onehot
);

    // Walk from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid  = |req;
        idx    = '0;
        onehot = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx       = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/age_matrix_scheduler.sv
// Age-matrix issue scheduler: allocates entries at the lowest free slot and
// grants the oldest entry whose request bit is set.
module age_matrix_scheduler
    import issue_pkg::*;
#(
    parameter int NUM_ENTRIES = IQ_DEPTH,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    output logic [IDX_W-1:0]       alloc_idx,
    input  logic [NUM_ENTRIES-1:0] request_mask,
    input  logic                   issue_ready,
    output logic                   grant_valid,
    output logic [NUM_ENTRIES-1:0] grant_onehot,
    output logic [IDX_W-1:0]       grant_idx,
    output logic [NUM_ENTRIES-1:0] entry_valid,
    output logic [IDX_W:0]         free_count,
    output logic                   full,
    output logic                   empty
);

    // age[i][j] = 1 means entry i was allocated before entry j.
    logic [NUM_ENTRIES-1:0] age [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] eligible;
    logic [NUM_ENTRIES-1:0] oldest;
    logic [NUM_ENTRIES-1:0] free_slots;
    logic [NUM_ENTRIES-1:0] alloc_onehot;
    logic [NUM_ENTRIES-1:0] oldest_onehot;
    logic [IDX_W-1:0]       oldest_idx;
    logic                   free_any;
    logic                   oldest_any;
    logic [IDX_W:0]         valid_count;
    logic                   alloc_fire;
    logic                   issue_fire;

    assign free_slots = ~entry_valid;

    priority_encoder #(
        .WIDTH (NUM_ENTRIES),
        .IDX_W (IDX_W)
    ) alloc_enc (
        .req    (free_slots),
        .valid  (free_any),
        .idx    (alloc_idx),
        .onehot (alloc_onehot)
    );

    always_comb begin
        valid_count = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_count = valid_count + (IDX_W+1)'(entry_valid[i]);
        end
    end

    assign free_count  = (IDX_W+1)'(NUM_ENTRIES) - valid_count;
    assign full        = ~free_any;
    assign empty       = (free_count == (IDX_W+1)'(NUM_ENTRIES));
    assign alloc_ready = ~full;

    // An eligible entry is oldest when no other eligible entry is older than it.
    always_comb begin
        eligible = entry_valid & request_mask;
        oldest   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            oldest[i] = eligible[i];
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (eligible[j] && age[j][i]) begin
                    oldest[i] = 1'b0;
                end
            end
        end
    end

    priority_encoder #(
        .WIDTH (NUM_ENTRIES),
        .IDX_W (IDX_W)
    ) grant_enc (
        .req    (oldest),
        .valid  (oldest_any),
        .idx    (oldest_idx),
        .onehot (oldest_onehot)
    );

    assign grant_valid  = oldest_any & ~flush;
    assign grant_onehot = grant_valid ? oldest_onehot : '0;
    assign grant_idx    = grant_valid ? oldest_idx : '0;

    assign alloc_fire = alloc_valid & alloc_ready & ~flush;
    assign issue_fire = grant_valid & issue_ready;

    // The issued slot and the allocated slot can never coincide: one is valid,
    // the other free. A freed row/column is rewritten on its next allocation.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            entry_valid <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                age[i] <= '0;
            end
        end else begin
            if (issue_fire) begin
                entry_valid[grant_idx] <= 1'b0;
            end
            if (alloc_fire) begin
                entry_valid[alloc_idx] <= 1'b1;
                age[alloc_idx]         <= '0;
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (IDX_W'(i) != alloc_idx) begin
                        age[i][alloc_idx] <= entry_valid[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_age_matrix_scheduler.sv
// Self-checking bench for age_matrix_scheduler: directed vector table,
// corner-case sequences and a randomized run against a FIFO-order model.
module tb_age_matrix_scheduler;
    import issue_pkg::*;

    localparam int N = IQ_DEPTH;
    localparam int W = IQ_IDX_W;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         alloc_valid;
    logic         alloc_ready;
    iq_idx_t      alloc_idx;
    logic [N-1:0] request_mask;
    logic         issue_ready;
    logic         grant_valid;
    logic [N-1:0] grant_onehot;
    iq_idx_t      grant_idx;
    logic [N-1:0] entry_valid;
    logic [W:0]   free_count;
    logic         full;
    logic         empty;

    always #5 clk = ~clk;

    age_matrix_scheduler #(
        .NUM_ENTRIES (N),
        .IDX_W       (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_idx    (alloc_idx),
        .request_mask (request_mask),
        .issue_ready  (issue_ready),
        .grant_valid  (grant_valid),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .entry_valid  (entry_valid),
        .free_count   (free_count),
        .full         (full),
        .empty        (empty)
    );

    typedef struct {
        logic         alloc_ready;
        iq_idx_t      alloc_idx;
        logic         grant_valid;
        logic [N-1:0] grant_onehot;
        iq_idx_t      grant_idx;
        logic [N-1:0] entry_valid;
        logic [W:0]   free_count;
        logic         full;
        logic         empty;
    } exp_t;

    typedef struct {
        logic         rst;
        logic         fl;
        logic         av;
        logic [N-1:0] rm;
        logic         ir;
        iq_idx_t      e_aidx;
        logic         e_gv;
        iq_idx_t      e_gi;
        logic [W:0]   e_fc;
        logic [N-1:0] e_ev;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy plus a list of entries in allocation order.
    logic [N-1:0] m_valid = '0;
    int           m_order[$];
    exp_t         exp_q[$];
    exp_t         cur;
    logic         cur_rst, cur_fl, cur_av, cur_ir;

    vec_t vecs[25];

    function automatic exp_t modelExpect(input logic fl, input logic [N-1:0] rm);
        exp_t e;
        int   fc;
        fc = 0;
        for (int i = 0; i < N; i++) if (!m_valid[i]) fc++;
        e.entry_valid  = m_valid;
        e.free_count   = (W+1)'(fc);
        e.full         = (fc == 0);
        e.empty        = (fc == N);
        e.alloc_ready  = (fc != 0);
        e.alloc_idx    = '0;
        for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) e.alloc_idx = iq_idx_t'(i);
        e.grant_valid  = 1'b0;
        e.grant_idx    = '0;
        e.grant_onehot = '0;
        if (!fl) begin
            foreach (m_order[k]) begin
                if (!e.grant_valid && rm[m_order[k]]) begin
                    e.grant_valid               = 1'b1;
                    e.grant_idx                 = iq_idx_t'(m_order[k]);
                    e.grant_onehot[m_order[k]]  = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic av,
                                 input logic [N-1:0] rm, input logic ir);
        reset        = r;
        flush        = f;
        alloc_valid  = av;
        request_mask = rm;
        issue_ready  = ir;
        cur_rst = r; cur_fl = f; cur_av = av; cur_ir = ir;
        cur = modelExpect(f, rm);
        exp_q.push_back(cur);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: no expected record queued at %0t", $time);
            return;
        end
        e = exp_q.pop_front();
        checkVal("sb_alloc_ready",  32'(alloc_ready),  32'(e.alloc_ready));
        checkVal("sb_alloc_idx",    32'(alloc_idx),    32'(e.alloc_idx));
        checkVal("sb_grant_valid",  32'(grant_valid),  32'(e.grant_valid));
        checkVal("sb_grant_onehot", 32'(grant_onehot), 32'(e.grant_onehot));
        checkVal("sb_grant_idx",    32'(grant_idx),    32'(e.grant_idx));
        checkVal("sb_entry_valid",  32'(entry_valid),  32'(e.entry_valid));
        checkVal("sb_free_count",   32'(free_count),   32'(e.free_count));
        checkVal("sb_full",         32'(full),         32'(e.full));
        checkVal("sb_empty",        32'(empty),        32'(e.empty));
    endtask

    task automatic finishCycle();
        int pos;
        @(posedge clk);
        if (cur_rst || cur_fl) begin
            m_valid = '0;
            m_order.delete();
        end else begin
            if (cur.grant_valid && cur_ir) begin
                m_valid[cur.grant_idx] = 1'b0;
                pos = -1;
                foreach (m_order[k]) if (m_order[k] == int'(cur.grant_idx)) pos = k;
                if (pos >= 0) m_order.delete(pos);
            end
            if (cur_av && cur.alloc_ready) begin
                m_valid[cur.alloc_idx] = 1'b1;
                m_order.push_back(int'(cur.alloc_idx));
            end
        end
        #1;
    endtask

    initial begin
        //          rst   fl    av    rm       ir    aidx  gv    gi    fc    ev
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 3'd4, 4'b0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 3'd4, 4'b0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 2'd0, 3'd3, 4'b0001};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 2'd0, 3'd2, 4'b0011};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 2'd0, 3'd1, 4'b0111};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'b1010, 1'b0, 2'd0, 1'b1, 2'd1, 3'd0, 4'b1111};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'b1010, 1'b1, 2'd0, 1'b1, 2'd1, 3'd0, 4'b1111};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b1010, 1'b1, 2'd1, 1'b1, 2'd3, 3'd1, 4'b1101};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 2'd0, 3'd2, 4'b0101};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 2'd0, 3'd2, 4'b0101};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 3'd4, 4'b0000};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 2'd0, 3'd3, 4'b0001};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 2'd0, 3'd2, 4'b0011};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 2'd0, 3'd1, 4'b0111};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 2'd0, 3'd0, 4'b1111};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 3'd1, 4'b1110};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 2'd0, 1'b1, 2'd1, 3'd0, 4'b1111};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd0, 1'b1, 2'd2, 3'd0, 4'b1111};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 2'd0, 3'd1, 4'b1011};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 2'd2, 1'b0, 2'd0, 3'd1, 4'b1011};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 2'd0, 3'd4, 4'b0000};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 3'd4, 4'b0000};
        vecs[22] = '{1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd1, 1'b1, 2'd0, 3'd3, 4'b0001};
        vecs[23] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 3'd3, 4'b0010};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 2'd2, 1'b1, 2'd1, 3'd2, 4'b0011};

        reset        = 1'b1;
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        request_mask = '0;
        issue_ready  = 1'b0;
        @(posedge clk);
        #1;
        m_valid = '0;
        m_order.delete();

        $display("[TB] directed vector table");
        for (int v = 0; v < 25; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].fl, vecs[v].av, vecs[v].rm, vecs[v].ir);
            @(negedge clk);
            checkOutput();
            checkVal($sformatf("vec%0d_alloc_idx", v),   32'(alloc_idx),   32'(vecs[v].e_aidx));
            checkVal($sformatf("vec%0d_grant_valid", v), 32'(grant_valid), 32'(vecs[v].e_gv));
            checkVal($sformatf("vec%0d_grant_idx", v),   32'(grant_idx),   32'(vecs[v].e_gi));
            checkVal($sformatf("vec%0d_free_count", v),  32'(free_count),  32'(vecs[v].e_fc));
            checkVal($sformatf("vec%0d_entry_valid", v), 32'(entry_valid), 32'(vecs[v].e_ev));
            finishCycle();
        end

        $display("[TB] reset overriding flush, alloc and issue");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
        @(negedge clk);
        checkOutput();
        checkVal("rst_mid_grant_valid", 32'(grant_valid), 32'(1'b0));
        finishCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0011, 1'b1);
        @(negedge clk);
        checkOutput();
        checkVal("rst_after_entry_valid", 32'(entry_valid), 32'(4'b0000));
        checkVal("rst_after_empty",       32'(empty),       32'(1'b1));
        checkVal("rst_after_grant_valid", 32'(grant_valid), 32'(1'b0));
        finishCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
        @(negedge clk);
        checkOutput();
        checkVal("rst_realloc_onehot", 32'(grant_onehot), 32'(4'b0001));
        finishCycle();

        $display("[TB] randomized alloc/issue/flush/reset run");
        for (int c = 0; c < 10000; c++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 3),
                          ($urandom_range(0, 9) < 6), N'($urandom), $urandom_range(0, 1) == 1);
            @(negedge clk);
            checkOutput();
            finishCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
